// File: rtl/mpu_init_seq.sv
// Power-on register initialisation sequencer for an MPU-class IMU: walks a fixed
// seven-entry {addr,data} table through an external SPI register-write engine.
module mpu_init_seq #(
  parameter int unsigned GAP_CYCLES = 100,
  parameter int unsigned RESET_WAIT = 1000,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       spi_busy,
  input  logic       spi_finish,
  output logic       spi_start,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] idx
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitFin, StGap, StDone, StErr} state_e;

  // Gap counter is loaded with length-1 and expires when it reads zero.
  localparam logic [15:0] GapLast   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] RstLast   = 16'(RESET_WAIT - 1);
  localparam logic [15:0] TmoLast   = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LastEntry = 3'd6;

  state_e      r_state;
  logic [15:0] r_tmo;
  logic [15:0] r_gap;
  logic [2:0]  r_idx;
  logic        r_start;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;

  logic [2:0]  w_idx_inc;
  logic [15:0] w_entry_next;
  logic [15:0] w_entry_first;

  function automatic logic [15:0] table_entry(input logic [2:0] i);
    case (i)
      3'd0:    table_entry = 16'h6B80;
      3'd1:    table_entry = 16'h6B01;
      3'd2:    table_entry = 16'h6A10;
      3'd3:    table_entry = 16'h1900;
      3'd4:    table_entry = 16'h1A03;
      3'd5:    table_entry = 16'h1B18;
      3'd6:    table_entry = 16'h1C08;
      default: table_entry = 16'h0000;
    endcase
  endfunction

  assign w_idx_inc     = r_idx + 3'd1;
  assign w_entry_next  = table_entry(w_idx_inc);
  assign w_entry_first = table_entry(3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_tmo   <= 16'd0;
      r_gap   <= 16'd0;
      r_idx   <= 3'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      unique case (r_state)
        StIdle, StDone, StErr: begin
          if (go) begin
            r_state          <= StIssue;
            r_idx            <= 3'd0;
            r_tmo            <= 16'd0;
            r_start          <= 1'b1;
            {r_addr, r_data} <= w_entry_first;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
          end
        end
        StIssue, StWaitFin: begin
          r_tmo <= r_tmo + 16'd1;
          // Completion wins over timeout; a finish while still issuing skips WAIT_FIN.
          if (spi_finish) begin
            r_state <= StGap;
            r_start <= 1'b0;
            r_gap   <= (r_idx == 3'd0) ? RstLast : GapLast;
          end else if (r_tmo == TmoLast) begin
            r_state <= StErr;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if ((r_state == StIssue) && spi_busy) begin
            r_state <= StWaitFin;
            r_start <= 1'b0;
          end
        end
        StGap: begin
          if (r_gap == 16'd0) begin
            if (r_idx == LastEntry) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state          <= StIssue;
              r_idx            <= w_idx_inc;
              r_tmo            <= 16'd0;
              r_start          <= 1'b1;
              {r_addr, r_data} <= w_entry_next;
            end
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign spi_start = r_start;
  assign spi_addr  = r_addr;
  assign spi_data  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign idx       = r_idx;

endmodule

// File: tb/tb_mpu_init_seq.sv
// Randomised scoreboard bench for mpu_init_seq: a reactive SPI engine model, a write
// monitor that checks each issued write and gap length, and end-of-sequence checks.
module tb_mpu_init_seq;

  localparam int GapCycles = 5;
  localparam int ResetWait = 12;
  localparam int Timeout   = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go_main = 1'b0;
  logic       go_stray = 1'b0;
  logic       spi_busy = 1'b0;
  logic       spi_finish = 1'b0;
  logic       w_go;
  logic       spi_start;
  logic [7:0] spi_addr;
  logic [7:0] spi_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] idx;

  assign w_go = go_main | go_stray;

  always #5 clk = ~clk;

  mpu_init_seq #(
    .GAP_CYCLES(GapCycles),
    .RESET_WAIT(ResetWait),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (w_go),
    .spi_busy  (spi_busy),
    .spi_finish(spi_finish),
    .spi_start (spi_start),
    .spi_addr  (spi_addr),
    .spi_data  (spi_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .idx       (idx)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] ref_addr [7] = '{8'h6B, 8'h6B, 8'h6A, 8'h19, 8'h1A, 8'h1B, 8'h1C};
  logic [7:0] ref_data [7] = '{8'h80, 8'h01, 8'h10, 8'h00, 8'h03, 8'h18, 8'h08};

  int vectors = 0;
  int miscompares = 0;

  // SPI engine model configuration and state
  int hang_idx = -1;
  int lat_lo = 40;
  int lat_hi = 40;
  bit rnd_busy = 1'b0;
  bit stray_en = 1'b0;
  bit sp_active = 1'b0;
  bit sp_hang = 1'b0;
  int sp_cnt = 0;
  int sp_lat = 0;

  // monitor state
  int         cyc = 0;
  int         start_cyc = 0;
  int         err_cyc = 0;
  int         m_fin_cyc = 0;
  logic [2:0] m_fin_idx = 3'd0;
  bit         m_prev_start = 1'b0;
  bit         m_prev_err = 1'b0;
  bit         m_wr_open = 1'b0;
  bit         m_have_fin = 1'b0;
  wr_t        m_cur = '0;
  int         rnd_hang = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Busy follows a start by one cycle; finish arrives sp_lat cycles later unless hung.
  always @(negedge clk) begin
    spi_finish = 1'b0;
    go_stray   = 1'b0;
    if (rst || !busy) begin
      sp_active = 1'b0;
      spi_busy  = 1'b0;
    end else if (sp_active) begin
      sp_cnt++;
      if (sp_cnt >= sp_lat && !sp_hang) begin
        spi_finish = 1'b1;
        spi_busy   = 1'b0;
        sp_active  = 1'b0;
      end
    end else if (spi_start) begin
      sp_active = 1'b1;
      sp_cnt    = 0;
      sp_lat    = int'($urandom_range(lat_hi, lat_lo));
      sp_hang   = (int'(idx) == hang_idx);
      spi_busy  = rnd_busy ? 1'($urandom_range(1, 0)) : 1'b1;
    end else if (stray_en && $urandom_range(7, 0) == 0) begin
      // DUT is between writes here: these must be ignored
      spi_finish = 1'b1;
      go_stray   = 1'b1;
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        m_prev_start = 1'b0;
        m_prev_err   = 1'b0;
        m_wr_open    = 1'b0;
        m_have_fin   = 1'b0;
      end else begin
        if (spi_finish && m_wr_open) begin
          chk("addr_held", {24'd0, spi_addr}, {24'd0, m_cur.addr});
          chk("data_held", {24'd0, spi_data}, {24'd0, m_cur.data});
          m_wr_open  = 1'b0;
          m_have_fin = 1'b1;
          // finish was captured at the edge just passed: it belongs to the previous cycle
          m_fin_cyc  = cyc - 1;
          m_fin_idx  = m_cur.idx;
        end
        if (spi_start && !m_prev_start) begin
          if (exp_q.size() == 0) begin
            chk("write_expected", exp_q.size(), 1);
          end else begin
            m_cur = exp_q.pop_front();
            chk("wr_idx", {29'd0, idx}, {29'd0, m_cur.idx});
            chk("wr_addr", {24'd0, spi_addr}, {24'd0, m_cur.addr});
            chk("wr_data", {24'd0, spi_data}, {24'd0, m_cur.data});
            if (m_have_fin && m_cur.idx != 3'd0)
              chk("gap_len", cyc - m_fin_cyc, ((m_fin_idx == 3'd0) ? ResetWait : GapCycles) + 1);
          end
          m_have_fin = 1'b0;
          m_wr_open  = 1'b1;
          start_cyc  = cyc;
        end
        if (error && !m_prev_err) err_cyc = cyc;
        m_prev_start = spi_start;
        m_prev_err   = error;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_spi_start"}, {31'd0, spi_start}, 0);
    chk({tag, "_spi_addr"}, {24'd0, spi_addr}, 0);
    chk({tag, "_spi_data"}, {24'd0, spi_data}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_error"}, {31'd0, error}, 0);
    chk({tag, "_idx"}, {29'd0, idx}, 0);
  endtask

  task automatic push_writes(input int last);
    for (int i = 0; i <= last; i++) exp_q.push_back('{3'(i), ref_addr[i], ref_data[i]});
  endtask

  task automatic pulse_go();
    go_main = 1'b1;
    @(negedge clk);
    go_main = 1'b0;
  endtask

  task automatic run_seq(input int hang, input int lo, input int hi, input bit rb, input bit st);
    int last;
    int n;
    last     = (hang < 0) ? 6 : hang;
    hang_idx = hang;
    lat_lo   = lo;
    lat_hi   = hi;
    rnd_busy = rb;
    stray_en = st;
    push_writes(last);
    pulse_go();
    n = 0;
    while (!(done || error) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    stray_en = 1'b0;
    chk("seq_ends", {31'd0, done | error}, 1);
    chk("done", {31'd0, done}, {31'd0, hang < 0});
    chk("error", {31'd0, error}, {31'd0, hang >= 0});
    chk("busy_end", {31'd0, busy}, 0);
    chk("start_end", {31'd0, spi_start}, 0);
    chk("idx_end", {29'd0, idx}, last);
    chk("writes_left", exp_q.size(), 0);
    if (hang >= 0) chk("timeout_len", err_cyc - start_cyc, Timeout);
    exp_q.delete();
  endtask

  task automatic reset_mid();
    int n;
    hang_idx = -1;
    lat_lo   = 20;
    lat_hi   = 20;
    rnd_busy = 1'b0;
    stray_en = 1'b0;
    push_writes(6);
    pulse_go();
    n = 0;
    while (!(idx == 3'd2 && busy && !spi_start && sp_active) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_entry2_wait", {31'd0, n < 4000}, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_start", {31'd0, spi_start}, 0);
    chk("post_rst_idx", {29'd0, idx}, 0);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_start", {31'd0, spi_start}, 0);
    run_seq(-1, 40, 40, 1'b0, 1'b0);   // nominal
    run_seq(3, 5, 15, 1'b0, 1'b0);     // entry 3 never finishes
    run_seq(-1, 1, 20, 1'b1, 1'b0);    // recovery from ERR
    reset_mid();
    run_seq(-1, 1, 10, 1'b0, 1'b1);    // stray go/finish between writes
    run_seq(-1, 1, 10, 1'b1, 1'b0);    // restart from DONE
    for (int r = 0; r < 12; r++) begin
      rnd_hang = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
      run_seq(rnd_hang, 1, int'($urandom_range(25, 1)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
